// File: rtl/diff_reconstruct.sv
// diff_reconstruct: rebuilds Ain from (Bin, |Ain-Bin|, Sign) with a fixed
// three-cycle latency per operation.
//
// Optional feature: define DIFF_SAT_EN to saturate overflowing results
// (ADD clamps to 4'hF, SUB clamps to 4'h0). Without it the result wraps
// modulo 16. Ovf is reported in both builds.
module diff_reconstruct (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Start,
  input  logic [3:0] Bin,
  input  logic [3:0] Mag,
  input  logic       Sign,
  output logic [3:0] Output,
  output logic       Done,
  output logic       Busy,
  output logic       Ovf,
  output logic       Err
);

  localparam int unsigned W  = 4;
  localparam int unsigned WX = W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    ADD   = 2'b10,
    SUB   = 2'b11
  } step_t;

  step_t          step_q, step_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [W-1:0]   mag_q, mag_d;
  logic           sign_q, sign_d;
  logic [W-1:0]   out_d;
  logic           done_d, busy_d, ovf_d, err_d;
  logic [WX-1:0]  sum_add_c, sum_sub_c;

  // 5-bit adder/subtractor on the captured operands; bit W is carry / not-borrow
  always_comb begin
    sum_add_c = {1'b0, bin_q} + {1'b0, mag_q};
    sum_sub_c = {1'b0, bin_q} + {1'b0, ~mag_q} + WX'(1);
  end

  // Step register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q <= IDLE;
    end else begin
      step_q <= step_d;
    end
  end

  // Next-step and next-register values; everything holds unless a step updates it
  always_comb begin
    step_d = step_q;
    bin_d  = bin_q;
    mag_d  = mag_q;
    sign_d = sign_q;
    out_d  = Output;
    done_d = 1'b0;
    busy_d = Busy;
    ovf_d  = Ovf;
    err_d  = Err;

    case (step_q)
      IDLE: begin
        if (Start) begin
          bin_d  = Bin;
          mag_d  = Mag;
          sign_d = Sign;
          busy_d = 1'b1;
          step_d = CHECK;
        end
      end

      CHECK: begin
        // Sign=1 with Mag=0 is inconsistent; route it through SUB so Output=Bin
        if (sign_q && (mag_q != '0)) begin
          step_d = ADD;
        end else begin
          step_d = SUB;
        end
      end

      ADD: begin
        ovf_d = sum_add_c[W];
`ifdef DIFF_SAT_EN
        out_d = sum_add_c[W] ? {W{1'b1}} : sum_add_c[W-1:0];
`else
        out_d = sum_add_c[W-1:0];
`endif
        err_d  = 1'b0;
        done_d = 1'b1;
        busy_d = 1'b0;
        step_d = IDLE;
      end

      SUB: begin
        ovf_d = ~sum_sub_c[W];
`ifdef DIFF_SAT_EN
        out_d = (~sum_sub_c[W]) ? {W{1'b0}} : sum_sub_c[W-1:0];
`else
        out_d = sum_sub_c[W-1:0];
`endif
        err_d  = sign_q && (mag_q == '0);
        done_d = 1'b1;
        busy_d = 1'b0;
        step_d = IDLE;
      end

      default: begin
        step_d = IDLE;
      end
    endcase
  end

  // Captured operands and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bin_q  <= '0;
      mag_q  <= '0;
      sign_q <= 1'b0;
      Output <= '0;
      Done   <= 1'b0;
      Busy   <= 1'b0;
      Ovf    <= 1'b0;
      Err    <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      mag_q  <= mag_d;
      sign_q <= sign_d;
      Output <= out_d;
      Done   <= done_d;
      Busy   <= busy_d;
      Ovf    <= ovf_d;
      Err    <= err_d;
    end
  end

endmodule

// File: tb/tb_diff_reconstruct.sv
// Bench for diff_reconstruct: directed cases, random operations, a held-Start
// stream and reset abort, all checked against an arithmetic reference.
module tb_diff_reconstruct;

  logic       CLK;
  logic       RST_N;
  logic       Start;
  logic [3:0] Bin;
  logic [3:0] Mag;
  logic       Sign;
  logic [3:0] Output;
  logic       Done;
  logic       Busy;
  logic       Ovf;
  logic       Err;

  int total = 0;
  int bad   = 0;

  diff_reconstruct dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .Start  (Start),
    .Bin    (Bin),
    .Mag    (Mag),
    .Sign   (Sign),
    .Output (Output),
    .Done   (Done),
    .Busy   (Busy),
    .Ovf    (Ovf),
    .Err    (Err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: recover Ain with plain integer arithmetic
  task automatic model(input int b, input int m, input int s,
                       output int o, output int ov, output int er);
    int a;
    er = (s == 1 && m == 0) ? 1 : 0;
    a  = (s == 1 && m != 0) ? b + m : b - m;
    ov = (a < 0 || a > 15) ? 1 : 0;
`ifdef DIFF_SAT_EN
    o = (a > 15) ? 15 : (a < 0) ? 0 : a;
`else
    o = a & 15;
`endif
  endtask

  // One isolated operation, inputs scrambled after capture
  task automatic do_op(input int b, input int m, input int s, input string tag);
    int eo, eov, eer;
    model(b, m, s, eo, eov, eer);
    @(negedge CLK);
    Start = 1'b1; Bin = 4'(b); Mag = 4'(m); Sign = 1'(s);
    @(posedge CLK); #1;
    chk({tag, ".busy_k"}, Busy, 1);
    chk({tag, ".done_k"}, Done, 0);
    @(negedge CLK);
    Start = 1'b0; Bin = 4'($urandom); Mag = 4'($urandom); Sign = 1'($urandom);
    @(posedge CLK); #1;
    chk({tag, ".busy_k1"}, Busy, 1);
    chk({tag, ".done_k1"}, Done, 0);
    @(posedge CLK); #1;
    chk({tag, ".done_k2"}, Done, 1);
    chk({tag, ".busy_k2"}, Busy, 0);
    chk({tag, ".out"}, Output, eo);
    chk({tag, ".ovf"}, Ovf, eov);
    chk({tag, ".err"}, Err, eer);
    @(posedge CLK); #1;
    chk({tag, ".done_k3"}, Done, 0);
    chk({tag, ".hold_out"}, Output, eo);
    chk({tag, ".hold_ovf"}, Ovf, eov);
  endtask

  int qb[$], qm[$], qs[$];

  initial begin
    int eo, eov, eer;
    int cb, cm, cs;
    RST_N = 1'b0; Start = 1'b0; Bin = '0; Mag = '0; Sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.out",  Output, 0);
    chk("rst.done", Done, 0);
    chk("rst.busy", Busy, 0);
    chk("rst.ovf",  Ovf, 0);
    chk("rst.err",  Err, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed cases
    do_op(3, 5, 1, "add_3_5");
    do_op(9, 4, 0, "sub_9_4");
    do_op(12, 7, 1, "ovf_add");
    do_op(2, 6, 0, "ovf_sub");
    do_op(7, 0, 1, "err_7");
    do_op(7, 0, 0, "noerr_7");
    do_op(0, 15, 1, "add_0_15");
    do_op(15, 15, 0, "sub_eq");
    do_op(15, 1, 1, "add_wrap16");
    do_op(0, 1, 0, "sub_neg1");

    // Random operations
    for (int i = 0; i < 40; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 1)), "rand");
    end

    // Start held high: captures every third edge, operands change every cycle
    for (int n = 0; n < 9; n++) begin
      @(negedge CLK);
      Start = 1'b1;
      Bin = 4'($urandom); Mag = 4'($urandom); Sign = 1'($urandom);
      if (n % 3 == 0) begin
        qb.push_back(int'(Bin)); qm.push_back(int'(Mag)); qs.push_back(int'(Sign));
      end
      @(posedge CLK); #1;
      chk("stream.busy", Busy, (n % 3 == 2) ? 0 : 1);
      chk("stream.done", Done, (n % 3 == 2) ? 1 : 0);
      if (n % 3 == 2) begin
        cb = qb.pop_front(); cm = qm.pop_front(); cs = qs.pop_front();
        model(cb, cm, cs, eo, eov, eer);
        chk("stream.out", Output, eo);
        chk("stream.ovf", Ovf, eov);
        chk("stream.err", Err, eer);
      end
    end
    @(negedge CLK);
    Start = 1'b0;

    // Leave nonzero Output and Err=1 behind, then abort an operation by reset
    do_op(9, 0, 1, "err_9");
    @(negedge CLK);
    Start = 1'b1; Bin = 4'd5; Mag = 4'd2; Sign = 1'b1;
    @(posedge CLK); #1;
    chk("abort.busy_k", Busy, 1);
    @(negedge CLK);
    Start = 1'b0;
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    chk("abort.out",  Output, 0);
    chk("abort.done", Done, 0);
    chk("abort.busy", Busy, 0);
    chk("abort.ovf",  Ovf, 0);
    chk("abort.err",  Err, 0);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("abort.no_done", Done, 0);
      chk("abort.no_busy", Busy, 0);
    end
    Start = 1'b0;
    #1;
    RST_N = 1'b1;
    do_op(1, 1, 1, "post_rst");

    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: got=0 expected=1");
    $fatal(1);
  end

endmodule
